// File: rtl/div_pkg.sv
// Shared definitions for the divider and its reconstructor: the default operand width
// and the reconstructor FSM state encoding.
package div_pkg;

  localparam int unsigned DivWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StChk,
    StMul,
    StAdd,
    StFin,
    StErr
  } div_state_e;

endpackage

// File: rtl/div_recon_dp.sv
// Reconstructor datapath: operand latches, shift-and-add multiplier accumulator and
// the final remainder addition, all in 2*WIDTH bits.
module div_recon_dp
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_mul,
  input  logic               i_add,
  input  logic [WIDTH-1:0]   i_coc,
  input  logic [WIDTH-1:0]   i_den,
  input  logic [WIDTH-1:0]   i_res,
  output logic               o_chk_bad,
  output logic               o_mul_last,
  output logic [2*WIDTH-1:0] o_sum
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_r;
  logic [2*WIDTH-1:0] r_acc;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] w_addend;

  assign w_addend   = {{WIDTH{1'b0}}, r_b} << r_cnt;
  assign o_sum      = r_acc + {{WIDTH{1'b0}}, r_r};
  assign o_chk_bad  = (r_b == '0) || (r_r >= r_b);
  assign o_mul_last = (r_cnt == CntW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_r   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_a   <= i_coc;
      r_b   <= i_den;
      r_r   <= i_res;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_mul) begin
      if (r_a[0]) begin
        r_acc <= r_acc + w_addend;
      end
      r_a   <= r_a >> 1;
      r_cnt <= r_cnt + CntW'(1);
    end else if (i_add) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/div_reconstructor.sv
// Rebuilds the dividend Num = Coc*Den + Res from divider outputs as a hardware self-check,
// flagging invalid triples and WIDTH-bit overflow.
module div_reconstructor
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] Coc,
  input  logic [WIDTH-1:0] Den,
  input  logic [WIDTH-1:0] Res,
  output logic             done,
  output logic             er,
  output logic [WIDTH-1:0] Num
);

  div_state_e         r_state;
  div_state_e         w_state_d;
  logic               w_load;
  logic               w_mul;
  logic               w_add;
  logic               w_chk_bad;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_sum;
  logic               r_done;
  logic               r_er;
  logic [WIDTH-1:0]   r_num;

  div_recon_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_load),
    .i_mul      (w_mul),
    .i_add      (w_add),
    .i_coc      (Coc),
    .i_den      (Den),
    .i_res      (Res),
    .o_chk_bad  (w_chk_bad),
    .o_mul_last (w_mul_last),
    .o_sum      (w_sum)
  );

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_mul     = 1'b0;
    w_add     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_load    = 1'b1;
          w_state_d = StChk;
        end
      end
      StChk:   w_state_d = w_chk_bad ? StErr : StMul;
      StMul: begin
        w_mul = 1'b1;
        if (w_mul_last) begin
          w_state_d = StAdd;
        end
      end
      StAdd: begin
        w_add     = 1'b1;
        w_state_d = StFin;
      end
      StFin:   w_state_d = StIdle;
      StErr:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are captured on the edge leaving ADD/ERR, so the result lands with the done pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
      r_done  <= 1'b0;
      r_er    <= 1'b0;
      r_num   <= '0;
    end else begin
      r_state <= w_state_d;
      r_done  <= (r_state == StAdd) || (r_state == StErr);
      if (w_load) begin
        r_er  <= 1'b0;
        r_num <= '0;
      end else if (r_state == StAdd) begin
        r_num <= w_sum[WIDTH-1:0];
        r_er  <= |w_sum[2*WIDTH-1:WIDTH];
      end else if (r_state == StErr) begin
        r_num <= '0;
        r_er  <= 1'b1;
      end
    end
  end

  assign done = r_done;
  assign er   = r_er;
  assign Num  = r_num;

endmodule

// File: tb/tb_div_reconstructor.sv
// Self-checking bench for div_reconstructor: expected results are queued at stimulus time
// and compared when done pulses.
module tb_div_reconstructor;

  typedef struct {
    logic [7:0] num;
    logic       er;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] coc;
  logic [7:0] den;
  logic [7:0] res;
  logic       done;
  logic       er;
  logic [7:0] num;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_reconstructor #(
    .WIDTH(8)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .start (start),
    .Coc   (coc),
    .Den   (den),
    .Res   (res),
    .done  (done),
    .er    (er),
    .Num   (num)
  );

  function automatic exp_t model(input logic [7:0] c, input logic [7:0] d, input logic [7:0] r);
    exp_t e;
    int   full;
    full = int'(c) * int'(d) + int'(r);
    if (d == 8'd0 || r >= d) begin
      e.num = 8'd0;
      e.er  = 1'b1;
      e.lat = 2;
    end else begin
      e.num = full[7:0];
      e.er  = (full > 255);
      e.lat = 10;
    end
    return e;
  endfunction

  // Drives one start pulse, queues the expected result, and returns edges from accept to done.
  task automatic drive_op(input logic [7:0] c, input logic [7:0] d, input logic [7:0] r,
                          output int lat);
    repeat (2) @(negedge clk);
    coc   = c;
    den   = d;
    res   = r;
    start = 1'b1;
    sb.push_back(model(c, d, r));
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    coc   = '0;
    den   = '0;
    res   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (done !== 1'b0 || er !== 1'b0 || num !== 8'd0) begin
      errors++;
      $display("FAIL reset: done=%b er=%b num=%0d want 0 0 0", done, er, num);
    end
  endtask

  task automatic test_normal();
    int   lat;
    exp_t e;
    drive_op(8'd13, 8'd7, 8'd5, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || num !== e.num || er !== e.er || e.num !== 8'd96) begin
      errors++;
      $display("FAIL normal: lat=%0d num=%0d er=%b want lat=%0d num=%0d er=%b",
               lat, num, er, e.lat, e.num, e.er);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || num !== 8'd96 || er !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: done=%b num=%0d er=%b want 0 96 0", i, done, num, er);
      end
    end
  endtask

  task automatic test_overflow();
    int   lat;
    exp_t e;
    drive_op(8'd200, 8'd2, 8'd1, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 10 || num !== 8'd145 || er !== 1'b1 || e.num !== 8'd145) begin
      errors++;
      $display("FAIL overflow: lat=%0d num=%0d er=%b want lat=10 num=145 er=1", lat, num, er);
    end
  endtask

  task automatic test_invalid();
    int   lat;
    exp_t e;
    drive_op(8'd5, 8'd0, 8'd0, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || num !== e.num || er !== e.er) begin
      errors++;
      $display("FAIL den_zero: lat=%0d num=%0d er=%b want lat=%0d num=%0d er=%b",
               lat, num, er, e.lat, e.num, e.er);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_width: done=%b want 0", done);
    end
    drive_op(8'd3, 8'd4, 8'd4, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 2 || num !== 8'd0 || er !== 1'b1) begin
      errors++;
      $display("FAIL res_ge_den: lat=%0d num=%0d er=%b want lat=2 num=0 er=1", lat, num, er);
    end
  endtask

  task automatic test_boundary();
    int   lat;
    exp_t e;
    drive_op(8'd255, 8'd1, 8'd0, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 10 || num !== 8'd255 || er !== 1'b0) begin
      errors++;
      $display("FAIL max_coc: lat=%0d num=%0d er=%b want lat=10 num=255 er=0", lat, num, er);
    end
    drive_op(8'd0, 8'd9, 8'd8, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || num !== 8'd8 || er !== 1'b0) begin
      errors++;
      $display("FAIL zero_coc: lat=%0d num=%0d er=%b want lat=10 num=8 er=0", lat, num, er);
    end
  endtask

  task automatic test_reset_mid();
    int   lat;
    int   seen;
    exp_t e;
    repeat (2) @(negedge clk);
    coc   = 8'd9;
    den   = 8'd10;
    res   = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (done !== 1'b0 || er !== 1'b0 || num !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: done=%b er=%b num=%0d want 0 0 0", done, er, num);
    end
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: pulses=%0d want 0", seen);
    end
    drive_op(8'd2, 8'd3, 8'd1, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 10 || num !== 8'd7 || er !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: lat=%0d num=%0d er=%b want lat=10 num=7 er=0", lat, num, er);
    end
  endtask

  task automatic test_back_to_back();
    int   nxt;
    int   ops;
    exp_t e;
    nxt = 0;
    ops = 0;
    repeat (3) @(negedge clk);
    for (int edge_i = 0; edge_i < 120; edge_i++) begin
      @(negedge clk);
      start = (edge_i < 100);
      coc   = 8'($urandom_range(0, 255));
      den   = 8'($urandom_range(0, 15));
      res   = 8'($urandom_range(0, 15));
      if (start && edge_i == nxt) begin
        e     = model(coc, den, res);
        nxt   = edge_i + e.lat + (e.er && e.num == 8'd0 && e.lat == 2 ? 1 : 2);
        e.lat = edge_i + e.lat;
        sb.push_back(e);
        ops++;
      end
      @(posedge clk);
      #1;
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stream_extra_done: edge=%0d", edge_i);
        end else begin
          e = sb.pop_front();
          if (e.lat !== edge_i || num !== e.num || er !== e.er) begin
            errors++;
            $display("FAIL stream: edge=%0d num=%0d er=%b want edge=%0d num=%0d er=%b",
                     edge_i, num, er, e.lat, e.num, e.er);
          end
        end
      end else if (sb.size() != 0 && sb[0].lat == edge_i) begin
        checks++;
        errors++;
        $display("FAIL stream_missing_done: edge=%0d num_want=%0d", edge_i, sb[0].num);
        void'(sb.pop_front());
      end
    end
    start = 1'b0;
    checks++;
    if (sb.size() != 0 || ops < 8) begin
      errors++;
      $display("FAIL stream_drain: pending=%0d ops=%0d want pending=0 ops>=8", sb.size(), ops);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_invalid();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_reconstructor.md
# div_reconstructor

Sequential inverse of the team's 8-bit divider. Given a quotient, divisor and remainder, it rebuilds the dividend Num = Coc*Den + Res using a shift-and-add multiplier followed by one addition. It flags invalid triples (Den = 0, Res ≥ Den) and results that overflow WIDTH bits. It sits beside the divider as a hardware self-check: the divider's Coc/Res outputs and its Den input feed this block, and Num is compared against the original dividend.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  request pulse or level; sampled only in IDLE
- Coc  in  WIDTH  quotient operand; latched when start is accepted
- Den  in  WIDTH  divisor operand; latched when start is accepted
- Res  in  WIDTH  remainder operand; latched when start is accepted
- done  out  1  one-cycle completion pulse
- er  out  1  error flag; valid while done = 1 and held until the next accepted start
- Num  out  WIDTH  reconstructed dividend; valid while done = 1 and held until the next accepted start

## Operation
- States: IDLE, CHK, MUL, ADD, FIN, ERR.
- IDLE:
  - start = 1 → latch A = Coc, B = Den, R = Res; clear acc (2*WIDTH bits) and cnt.
  - Clear er and Num.
  - Go to CHK.
- CHK:
  - B == 0, or R ≥ B → ERR.
  - Otherwise → MUL.
- MUL, one iteration per cycle:
  - If A[0] = 1, acc += B << cnt. All arithmetic is in 2*WIDTH bits, so the shift and add never truncate.
  - A >>= 1; cnt += 1.
  - After WIDTH iterations → ADD.
- ADD: acc += R, zero-extended to 2*WIDTH bits → FIN.
- FIN:
  - done = 1.
  - Num = acc[WIDTH-1:0].
  - er = 1 iff acc[2*WIDTH-1:WIDTH] ≠ 0 (overflow). On overflow Num still carries the low bits.
  - → IDLE.
- ERR: done = 1, er = 1, Num = 0 → IDLE.
- start is ignored in every state except IDLE; there is no abort input.
- Input changes after the accepting edge have no effect on the operation in flight.
- start held permanently high gives back-to-back operations, one accepted per IDLE visit.

## Timing
- Reset: RST = 1 at a rising edge forces state = IDLE, done = 0, er = 0, Num = 0, and clears acc, cnt, A, B, R. This is the same from any state; an operation in flight is discarded with no done pulse.
- Let t0 be the edge that accepts start.
- Valid path: done is high for exactly one cycle, following edge t0+WIDTH+2 (10 edges for WIDTH = 8). Next start is accepted no earlier than edge t0+WIDTH+4.
- Error path: done is high for exactly one cycle, following edge t0+2.
- done, er and Num are registered outputs with no combinational path from inputs.
- After the done pulse, er and Num keep their values through IDLE until the next accepted start clears them.

## Structure
- Shared package div_pkg holds:
  - the state encoding (IDLE, CHK, MUL, ADD, FIN, ERR) as a typedef;
  - the default WIDTH constant, shared with the divider so both stay aligned.
- Sub-module div_recon_dp holds the datapath (A/B/R registers, acc, cnt, shift-add). The top level holds the FSM and output registers. A single flat module is also acceptable.

## Test plan
- Normal: Coc = 13, Den = 7, Res = 5, start for one cycle → done 10 edges later, Num = 96, er = 0; Num and er unchanged for 5 following cycles.
- Overflow: Coc = 200, Den = 2, Res = 1 → Num = 145 (401 mod 256), er = 1, done on the normal schedule.
- Invalid triples:
  - Den = 0 → done following edge t0+2, er = 1, Num = 0.
  - Coc = 3, Den = 4, Res = 4 → the same error response.
- Boundary: Coc = 255, Den = 1, Res = 0 → Num = 255, er = 0; Coc = 0, Den = 9, Res = 8 → Num = 8, er = 0.
- Reset mid-operation: RST = 1 at edge t0+5 → done never pulses; er = 0 and Num = 0. A following start with Coc = 2, Den = 3, Res = 1 gives Num = 7 on schedule.
- Streaming: start held high, with inputs changed every cycle → each result matches the operands present at its accepting edge; start is ignored outside IDLE; exactly one done per operation.
